// File: rtl/instr_fetch_queue_pkg.sv
// Purpose: shared types and constants for the instruction fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_queue_pkg;

  // Default word shown to decode when nothing valid is at the queue head.
  localparam logic [31:0] DEFAULT_NOOP_WORD = 32'h0000_0000;

  // Sequential fetch stride (one 32-bit word).
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a free FIFO slot
    ST_REQ  = 2'd1,  // presenting a request, waiting for grant
    ST_WAIT = 2'd2,  // granted, waiting for the response word
    ST_DROP = 2'd3   // granted on a wrong path, response will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Purpose: synchronous FIFO of {pc, instr} entries with push, pop and clear.
// Latency: a pushed entry is visible at head_o one cycle after the push edge (no bypass).
// Backpressure: push is dropped when full unless a pop frees the slot that cycle; clear wins over push/pop.
//
// Ports: clk/rst (async active-low), push_i/wdata_i write side, pop_i read side,
// clear_i flushes all entries, head_o/count_o/full_o/empty_o status.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: head is only consumed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Purpose: fetch front end issuing word fetches and buffering {pc, instr} for decode.
// Latency: word reaches dec_* one cycle after mem_rvalid; one word per grant+response round trip.
// Backpressure: stops requesting while the FIFO is full; redirect flushes FIFO and drops in-flight data.
//
// Ports: clk, rst (async active-low); redirect/redirect_pc restart fetch;
// mem_req/mem_addr/mem_gnt request handshake, mem_rvalid/mem_rdata response;
// dec_valid/dec_instr/dec_pc/dec_ready decode-side valid/ready.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOOP_WORD = DEFAULT_NOOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic          push, pop;
  logic [CW-1:0] fifo_count, cnt_after_push;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  fifo_head, fifo_wdata;

  assign fifo_wdata = '{pc: req_pc_q, instr: mem_rdata};

  // A pop coinciding with redirect is ignored; the flush covers that entry.
  assign pop = dec_valid && dec_ready && !redirect;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .clear_i (redirect),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dec_valid = !fifo_empty;
  assign dec_instr = fifo_empty ? NOOP_WORD : fifo_head.instr;
  assign dec_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
  assign mem_addr  = fetch_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    push           = 1'b0;
    mem_req        = 1'b0;
    // Occupancy after this edge, including a same-cycle pop.
    cnt_after_push = fifo_count + CW'(1) - CW'(pop);

    unique case (state_q)
      // Only request when a slot is free, so the response always fits.
      ST_IDLE: if (!fifo_full) state_d = ST_REQ;
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_INC;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          push    = 1'b1;
          state_d = (cnt_after_push < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: if (mem_rvalid) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything. A grant in the same cycle still owes a
    // response, so it must be drained through DROP.
    if (redirect) begin
      push       = 1'b0;
      fetch_pc_d = redirect_pc & ~32'h3;
      unique case (state_q)
        ST_REQ:  state_d = mem_gnt    ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = mem_rvalid ? ST_REQ  : ST_DROP;
        ST_DROP: state_d = mem_rvalid ? ST_REQ  : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end
  end

  // A response is only legal while one is owed.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst)
    mem_rvalid |-> (state_q == ST_WAIT || state_q == ST_DROP));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Purpose: randomized and directed self-checking bench for instr_fetch_queue.
// Latency: model tracks the decode-visible queue one edge at a time.
// Backpressure: exercised via random dec_ready, grant and response delays.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOOP_WORD(NOOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: what decode must see is the in-order list of right-path
  // PCs; the word for a PC is a fixed function of its address.
  logic [31:0] mq[$];
  logic [31:0] popped[$];
  logic [31:0] granted[$];
  bit          owed, owed_wrong;
  logic [31:0] owed_pc;
  int          lat;
  logic [31:0] exp_fetch;
  bit          chk_en = 1'b0;

  // Inputs presented during the previous cycle, applied to the model at the edge.
  bit          p_gnt, p_rv, p_rdy, p_redir, p_mreq;
  logic [31:0] p_maddr, p_rpc;

  // Stimulus knobs.
  int          gnt_pct = 100;
  int          lat_lo = 0, lat_hi = 0;
  int          cfg_rdy = 0;
  int          redir_pct = 0;
  bit          redir_now = 1'b0;
  bit          redir_on_en = 1'b0;
  logic [31:0] redir_on_addr, redir_tgt;
  int          last_redir_pops = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // which: 0 = popped list, 1 = granted list
  task automatic chk_list(input string nm, input int which, input int idx, input logic [31:0] exp);
    int sz;
    logic [31:0] v;
    sz = (which == 0) ? popped.size() : granted.size();
    checks++;
    if (idx >= sz) begin
      failures++;
      $display("FAIL %s: only %0d entries, required entry %0d = %h", nm, sz, idx, exp);
    end else begin
      v = (which == 0) ? popped[idx] : granted[idx];
      if (v !== exp) begin
        failures++;
        $display("FAIL %s: got %h required %h", nm, v, exp);
      end
    end
  endtask

  // Compare process: decode outputs against the model head every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (mq.size() > 0) begin
        chk("dec_valid", 32'(dec_valid), 32'd1);
        chk("dec_pc", dec_pc, mq[0]);
        chk("dec_instr", dec_instr, memf(mq[0]));
      end else begin
        chk("dec_valid_empty", 32'(dec_valid), 32'd0);
        chk("dec_instr_noop", dec_instr, NOOP);
        chk("dec_pc_zero", dec_pc, 32'h0);
      end
      if (mem_req) begin
        chk("one_outstanding", 32'(owed), 32'd0);
        chk("req_has_slot", 32'(mq.size() < DEPTH), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    // Apply the edge just taken to the model.
    if (mq.size() > 0 && p_rdy && !p_redir) popped.push_back(mq.pop_front());
    if (p_rv) begin
      if (!owed_wrong && !p_redir) begin
        chk("no_overflow", 32'(mq.size() < DEPTH), 32'd1);
        mq.push_back(owed_pc);
      end
      owed = 1'b0;
    end
    if (p_gnt) begin
      chk("grant_addr", p_maddr, exp_fetch);
      granted.push_back(p_maddr);
      exp_fetch  = exp_fetch + 32'd4;
      owed       = 1'b1;
      owed_pc    = p_maddr;
      owed_wrong = p_redir;
      lat        = int'($urandom_range(lat_hi, lat_lo));
    end else if (p_mreq && !p_redir) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_held", mem_addr, p_maddr);
    end
    if (p_redir) begin
      mq.delete();
      exp_fetch = p_rpc & ~32'h3;
      if (owed) owed_wrong = 1'b1;
    end

    // Drive inputs for the next edge.
    mem_gnt    = mem_req && (int'($urandom_range(100, 1)) <= gnt_pct);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    if (owed) begin
      if (lat == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memf(owed_pc);
      end else begin
        lat--;
      end
    end
    dec_ready = (cfg_rdy == 2) ? 1'($urandom_range(1, 0)) : (cfg_rdy == 1);
    redirect  = 1'b0;
    if (redir_now) begin
      redirect = 1'b1; redirect_pc = redir_tgt; redir_now = 1'b0;
    end else if (redir_on_en && mem_gnt && mem_addr == redir_on_addr) begin
      redirect = 1'b1; redirect_pc = redir_tgt; redir_on_en = 1'b0;
    end else if (redir_pct > 0 && int'($urandom_range(100, 1)) <= redir_pct) begin
      redirect = 1'b1; redirect_pc = $urandom();
    end
    if (redirect) last_redir_pops = popped.size();
    p_gnt = mem_gnt; p_rv = mem_rvalid; p_rdy = dec_ready; p_redir = redirect;
    p_rpc = redirect_pc; p_mreq = mem_req; p_maddr = mem_addr;
  endtask

  // Asserts reset away from a clock edge and checks the reset outputs at once.
  task automatic do_reset(input bit late_rv);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, NOOP);
    chk("rst_dec_pc", dec_pc, 32'h0);
    if (late_rv) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    mq.delete(); popped.delete(); granted.delete();
    owed = 1'b0; owed_wrong = 1'b0; owed_pc = 32'h0; lat = 0; exp_fetch = RESET_PC;
    p_gnt = 0; p_rv = 0; p_rdy = 0; p_redir = 0; p_mreq = 0; p_maddr = 32'h0; p_rpc = 32'h0;
    redir_now = 1'b0; redir_on_en = 1'b0; last_redir_pops = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_en = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    int base;
    // 1: streaming with immediate grant and one-cycle response.
    gnt_pct = 100; lat_lo = 0; lat_hi = 0; cfg_rdy = 1; redir_pct = 0;
    do_reset(0);
    for (int i = 0; i < 100 && popped.size() < 4; i++) tick();
    chk_list("t1_pop0", 0, 0, 32'h0);
    chk_list("t1_pop1", 0, 1, 32'h4);
    chk_list("t1_pop2", 0, 2, 32'h8);
    chk_list("t1_pop3", 0, 3, 32'hC);
    chk_list("t1_gnt2", 1, 2, 32'h8);
    chk_list("t1_gnt3", 1, 3, 32'hC);

    // 2: decode stalled, FIFO fills then fetch stops; one pop restarts at 16.
    cfg_rdy = 0;
    do_reset(0);
    repeat (30) tick();
    chk("t2_granted", 32'(granted.size()), 32'd4);
    chk("t2_dec_valid", 32'(dec_valid), 32'd1);
    chk("t2_dec_pc", dec_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_idle_no_req", 32'(mem_req), 32'd0);
    end
    cfg_rdy = 1; tick(); cfg_rdy = 0;
    for (int i = 0; i < 20 && granted.size() < 5; i++) tick();
    chk_list("t2_next_addr", 1, 4, 32'h10);
    chk_list("t2_popped", 0, 0, 32'h0);
    chk("t2_pop_count", 32'(popped.size()), 32'd1);

    // 3: redirect coinciding with the grant of PC 8.
    cfg_rdy = 1;
    do_reset(0);
    redir_on_en = 1'b1; redir_on_addr = 32'h8; redir_tgt = 32'h0000_0103;
    for (int i = 0; i < 100 && granted.size() < 4; i++) tick();
    chk_list("t3_gnt_pc8", 1, 2, 32'h8);
    chk_list("t3_gnt_after", 1, 3, 32'h100);
    base = last_redir_pops;
    for (int i = 0; i < 100 && popped.size() <= base; i++) tick();
    chk_list("t3_first_pop", 0, base, 32'h100);

    // 4: redirect with three buffered entries and decode ready.
    cfg_rdy = 0;
    do_reset(0);
    for (int i = 0; i < 100 && mq.size() < 3; i++) tick();
    chk("t4_filled", 32'(mq.size()), 32'd3);
    cfg_rdy = 1; redir_now = 1'b1; redir_tgt = 32'h40;
    tick();
    base = popped.size();
    tick();
    chk("t4_dec_valid", 32'(dec_valid), 32'd0);
    chk("t4_dec_instr", dec_instr, NOOP);
    chk("t4_no_pop", 32'(popped.size()), 32'(base));
    for (int i = 0; i < 100 && popped.size() <= base; i++) tick();
    chk_list("t4_first_pop", 0, base, 32'h40);

    // 5: address wrap past the top of memory.
    cfg_rdy = 1;
    do_reset(0);
    redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF8;
    for (int i = 0; i < 200 && popped.size() < 3; i++) tick();
    chk_list("t5_pop0", 0, 0, 32'hFFFF_FFF8);
    chk_list("t5_pop1", 0, 1, 32'hFFFF_FFFC);
    chk_list("t5_pop2", 0, 2, 32'h0000_0000);

    // 6: asynchronous reset while a response is pending.
    cfg_rdy = 0;
    do_reset(0);
    for (int i = 0; i < 100 && mq.size() < 2; i++) tick();
    lat_lo = 5; lat_hi = 5;
    for (int i = 0; i < 50 && !owed; i++) tick();
    tick();
    chk("t6_pre_dv", 32'(dec_valid), 32'd1);
    lat_lo = 0; lat_hi = 0; cfg_rdy = 1;
    do_reset(1);
    for (int i = 0; i < 100 && popped.size() < 1; i++) tick();
    chk_list("t6_first_fetch", 1, 0, RESET_PC);
    chk_list("t6_first_pop", 0, 0, RESET_PC);

    // 7: random grants, latencies, stalls and redirects.
    gnt_pct = 60; lat_lo = 0; lat_hi = 3; cfg_rdy = 2; redir_pct = 4;
    do_reset(0);
    repeat (4000) tick();
    redir_pct = 0;
    chk("rand_progress", 32'(popped.size() > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Fetch front end that sits upstream of the decode-stage instruction register. It issues word fetches to a variable-latency instruction memory over a request/grant/response handshake. Fetched words and their PCs are buffered in a small FIFO and presented to decode with valid/ready. Branch/jump redirects flush the FIFO and discard any in-flight response, so decode never sees a wrong-path word.

Parameters:
DEPTH, 4, FIFO entries (power of two, >= 2)
RESET_PC, 32'h00000000, first fetch address after reset
NOOP_WORD, 32'h00000000, value driven on dec_instr when dec_valid = 0

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
redirect  input  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
mem_req  output  1  fetch request valid
mem_addr  output  32  word-aligned fetch address, stable while mem_req && !mem_gnt
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  response word valid (exactly one per granted request, >= 1 cycle after grant)
mem_rdata  input  32  response word
dec_valid  output  1  head entry valid
dec_instr  output  32  head instruction, NOOP_WORD when !dec_valid
dec_pc  output  32  PC of head instruction, 0 when !dec_valid
dec_ready  input  1  decode consumes head this cycle (pop when dec_valid && dec_ready)

Behaviour:
- Reset (rst = 0, async): FIFO empty, count 0, fetch_pc = RESET_PC, state IDLE; mem_req 0, mem_addr RESET_PC, dec_valid 0, dec_instr NOOP_WORD, dec_pc 0.
- At most one outstanding request. FSM states:
  - IDLE: if count < DEPTH, go to REQ. A free slot is therefore guaranteed for the response.
  - REQ: mem_req = 1, mem_addr = fetch_pc. On mem_gnt, fetch_pc += 4 and go to WAIT.
  - WAIT: on mem_rvalid, push {mem_rdata, pc_of_request}. Then go to REQ if count_after_push < DEPTH, else IDLE.
  - DROP: wrong-path response pending. On mem_rvalid, discard the word and go to REQ.
- Back-to-back: a response and a new request may not occur in the same cycle. Throughput is one word per (grant latency + response latency) cycles.
- Push and pop in the same cycle: count unchanged. Pop on a full FIFO frees a slot visible to the IDLE check next cycle.
- Redirect (highest priority, same edge):
  - FIFO cleared (count 0); dec_valid = 0 from the next cycle. A pop in the same cycle is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - From REQ without mem_gnt: request withdrawn; next state REQ with the new address.
  - From REQ with mem_gnt in the same cycle: the request is considered accepted; go to DROP.
  - From WAIT without mem_rvalid: go to DROP.
  - From WAIT with mem_rvalid in the same cycle: word discarded (no push); go to REQ.
  - From DROP: stay in DROP. A mem_rvalid in the same cycle is discarded; then go to REQ.
  - From IDLE: go to REQ.
- fetch_pc wraps modulo 2^32: 32'hFFFFFFFC + 4 = 0.
- dec_instr/dec_pc come combinationally from the FIFO head register, not from mem_rdata. The FIFO has no bypass, so first-word latency is 1 cycle after mem_rvalid.
- mem_rvalid while in IDLE or REQ is a protocol violation. The word is ignored; a simulation-only assertion fires.

Decomposition:
- Shared package: NOOP_WORD, PC increment constant (4), fetch FSM state enum (IDLE, REQ, WAIT, DROP).
- One sub-module: fetch_fifo (synchronous FIFO of {pc, instr}, DEPTH entries, push/pop/clear, count/full/empty outputs). The FSM and PC logic stay in the top.

Test Plan:
- Reset, memory grants immediately and responds after 1 cycle, dec_ready = 1: dec_pc sequence 0, 4, 8, 12 with matching words; mem_addr never repeats.
- dec_ready = 0, memory always ready: exactly 4 words buffered (PCs 0..12), then mem_req = 0 and the FSM stays IDLE. Single dec_ready pulse: pops PC 0, next request is for address 16.
- Redirect to 32'h00000103 in the same cycle as a grant at PC 8: next request address 32'h00000100; the response for PC 8 is discarded; first dec_pc after redirect = 32'h00000100.
- Redirect while the FIFO holds 3 entries and dec_ready = 1: dec_valid = 0 the next cycle; the popped entry is never counted; dec_instr = NOOP_WORD.
- redirect_pc = 32'hFFFFFFF8, memory ready: dec_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- Assert rst low mid-WAIT, asynchronously: outputs return to reset values immediately. A late mem_rvalid after release is ignored, and the first fetch is at RESET_PC.
